// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - clocked 2R/1W register file with per-register busy scoreboard
// Reads are registered and see the same edge's write/reserve (write-first bypass).
module regfile_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] read_register_1,
  input  logic [ADDR_WIDTH-1:0] read_register_2,
  output logic [DATA_WIDTH-1:0] read_data_1,
  output logic [DATA_WIDTH-1:0] read_data_2,
  output logic                  read_busy_1,
  output logic                  read_busy_2,
  input  logic                  sig_reg_write,
  input  logic [ADDR_WIDTH-1:0] write_register,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  sig_reserve,
  input  logic [ADDR_WIDTH-1:0] reserve_register
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]      busy_q;
  logic [DEPTH-1:0]      busy_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic [DATA_WIDTH-1:0] rdata2_q, rdata2_d;
  logic                  rbusy1_q, rbusy1_d;
  logic                  rbusy2_q, rbusy2_d;
  logic                  write_ok;
  logic                  reserve_ok;

  assign write_ok   = sig_reg_write && !(ZERO_REG && (write_register == '0));
  assign reserve_ok = sig_reserve && !(ZERO_REG && (reserve_register == '0));

  // Reserve is applied after the write release so a same-cycle pair leaves the register busy.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (write_ok) begin
      regs_d[write_register] = write_data;
      busy_d[write_register] = 1'b0;
    end
    if (reserve_ok) begin
      busy_d[reserve_register] = 1'b1;
    end
    if (ZERO_REG) begin
      regs_d[0] = '0;
      busy_d[0] = 1'b0;
    end
  end

  always_comb begin
    rdata1_d = regs_d[read_register_1];
    rdata2_d = regs_d[read_register_2];
    rbusy1_d = busy_d[read_register_1];
    rbusy2_d = busy_d[read_register_2];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q   <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      rbusy1_q <= 1'b0;
      rbusy2_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q   <= busy_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      rbusy1_q <= rbusy1_d;
      rbusy2_q <= rbusy2_d;
    end
  end

  assign read_data_1 = rdata1_q;
  assign read_data_2 = rdata2_q;
  assign read_busy_1 = rbusy1_q;
  assign read_busy_2 = rbusy2_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed bench for regfile_scoreboard
// Two instances share stimulus: dut has the hard-wired zero register, dut_nz does not.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rr1, rr2, wr, resv;
  logic [31:0] wdata;
  logic        we, re;
  logic [31:0] rd1, rd2, nz_rd1, nz_rd2;
  logic        rb1, rb2, nz_rb1, nz_rb2;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b1)) dut (
    .clk(clk), .reset(reset),
    .read_register_1(rr1), .read_register_2(rr2),
    .read_data_1(rd1), .read_data_2(rd2),
    .read_busy_1(rb1), .read_busy_2(rb2),
    .sig_reg_write(we), .write_register(wr), .write_data(wdata),
    .sig_reserve(re), .reserve_register(resv)
  );

  regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b0)) dut_nz (
    .clk(clk), .reset(reset),
    .read_register_1(rr1), .read_register_2(rr2),
    .read_data_1(nz_rd1), .read_data_2(nz_rd2),
    .read_busy_1(nz_rb1), .read_busy_2(nz_rb2),
    .sig_reg_write(we), .write_register(wr), .write_data(wdata),
    .sig_reserve(re), .reserve_register(resv)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; re = 1'b0; wr = '0; resv = '0; wdata = '0; reset = 1'b0;
  endtask

  initial begin
    idle();
    rr1 = 5'd0; rr2 = 5'd0;
    reset = 1'b1;
    step();
    check("reset_rd1", rd1, 32'h0);
    check("reset_rd2", rd2, 32'h0);
    check("reset_rb1", {31'b0, rb1}, 32'h0);
    check("reset_rb2", {31'b0, rb2}, 32'h0);
    reset = 1'b0;

    for (int a = 0; a < 32; a += 2) begin
      rr1 = 5'(a); rr2 = 5'(a + 1);
      step();
      check($sformatf("init_rd1_r%0d", a), rd1, 32'h0);
      check($sformatf("init_rd2_r%0d", a + 1), rd2, 32'h0);
      check($sformatf("init_busy_r%0d", a), {30'b0, rb1, rb2}, 32'h0);
    end

    we = 1'b1; wr = 5'd5; wdata = 32'hDEADBEEF; rr1 = 5'd5; rr2 = 5'd6;
    step();
    check("bypass_r5", rd1, 32'hDEADBEEF);
    check("r6_untouched", rd2, 32'h0);

    idle(); rr1 = 5'd5; rr2 = 5'd5;
    step();
    check("same_addr_p1", rd1, 32'hDEADBEEF);
    check("same_addr_p2", rd2, 32'hDEADBEEF);

    we = 1'b1; wr = 5'd0; wdata = 32'h12345678; rr1 = 5'd0; rr2 = 5'd0;
    step();
    check("zero_reg_rd1", rd1, 32'h0);
    check("zero_reg_rb1", {31'b0, rb1}, 32'h0);
    check("nz_r0_rd1", nz_rd1, 32'h12345678);
    check("nz_r0_rd2", nz_rd2, 32'h12345678);

    idle(); re = 1'b1; resv = 5'd0; rr1 = 5'd0;
    step();
    check("zero_reserve_busy", {31'b0, rb1}, 32'h0);
    check("nz_reserve_busy", {31'b0, nz_rb1}, 32'h1);

    idle(); re = 1'b1; resv = 5'd7; rr2 = 5'd7;
    step();
    check("reserve_r7_busy", {31'b0, rb2}, 32'h1);
    check("reserve_r7_data", rd2, 32'h0);

    idle(); rr2 = 5'd7;
    step();
    check("r7_busy_held", {31'b0, rb2}, 32'h1);

    we = 1'b1; wr = 5'd7; wdata = 32'hA5A5A5A5;
    step();
    check("release_r7_busy", {31'b0, rb2}, 32'h0);
    check("release_r7_data", rd2, 32'hA5A5A5A5);

    idle(); we = 1'b1; re = 1'b1; wr = 5'd9; resv = 5'd9; wdata = 32'h00000042; rr1 = 5'd9;
    step();
    check("wr_res_r9_data", rd1, 32'h00000042);
    check("wr_res_r9_busy", {31'b0, rb1}, 32'h1);

    idle(); rr1 = 5'd9;
    step();
    check("r9_busy_held", {31'b0, rb1}, 32'h1);

    idle(); we = 1'b1; wr = 5'd3; wdata = 32'hFFFFFFFF;
    step();
    idle(); re = 1'b1; resv = 5'd4; rr1 = 5'd3; rr2 = 5'd4;
    step();
    check("pre_reset_r3", rd1, 32'hFFFFFFFF);
    check("pre_reset_r4_busy", {31'b0, rb2}, 32'h1);

    idle(); reset = 1'b1; we = 1'b1; wr = 5'd3; wdata = 32'h11111111;
    re = 1'b1; resv = 5'd4; rr1 = 5'd3; rr2 = 5'd4;
    step();
    check("in_reset_rd1", rd1, 32'h0);
    check("in_reset_rb2", {31'b0, rb2}, 32'h0);

    idle(); rr1 = 5'd3; rr2 = 5'd4;
    step();
    check("post_reset_r3", rd1, 32'h0);
    check("post_reset_r4_busy", {31'b0, rb2}, 32'h0);

    rr1 = 5'd5; rr2 = 5'd9;
    step();
    check("post_reset_r5", rd1, 32'h0);
    check("post_reset_r9_busy", {31'b0, rb2}, 32'h0);
    check("post_reset_nz_r9", nz_rd2, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
